// File: rtl/pipelined_adder_if.sv
// Handshake bundle for pipelined_adder: operand side (a, b, in_valid/in_ready)
// and result side (c, out_valid/out_ready). When PIPELINED_ADDER_SUB_EN is
// defined the bundle also carries the per-operation subtract select.
`timescale 1ns/1ps

interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   c;
    logic             out_valid;
    logic             out_ready;
`ifdef PIPELINED_ADDER_SUB_EN
    logic             sub;
`endif

    // Environment view: produces operands, consumes results.
    modport master (
`ifdef PIPELINED_ADDER_SUB_EN
        output sub,
`endif
        output a, b, in_valid, out_ready,
        input  in_ready, c, out_valid
    );

    // Adder view.
    modport slave (
`ifdef PIPELINED_ADDER_SUB_EN
        input  sub,
`endif
        input  a, b, in_valid, out_ready,
        output in_ready, c, out_valid
    );
endinterface

// File: rtl/pipelined_adder.sv
// pipelined_adder: c = a + b (WIDTH+1 bits) with the carry chain cut into
// STAGES equal chunks, one chunk resolved per register stage. The whole pipe
// advances together when the output slot is empty or being consumed, and holds
// otherwise, so back-pressure never drops or duplicates a result.
// Optional feature macro: PIPELINED_ADDER_SUB_EN adds a sub select that turns
// the operation into a + ~b + 1 (c[WIDTH] = 1 means no borrow).
`timescale 1ns/1ps

module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic            clk,
    input  logic            rst,
    pipelined_adder_if.slave bus
);
    localparam int CW = WIDTH / STAGES;

    generate
        if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
            $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
        end
    endgenerate

    logic                          adv;
    logic                          accept;
    logic [WIDTH-1:0]              b_eff;
    logic                          cin0;

    // Stage registers: operands travel whole; stage k only reads chunk k and
    // passes the rest on, so the already-digested low chunks are dead weight.
    logic [STAGES-1:0]             valid_q;
    logic [STAGES-1:0]             carry_q;
    logic [STAGES-1:0][WIDTH-1:0]  sum_q;
    logic [STAGES-1:0][WIDTH-1:0]  op_a_q;
    logic [STAGES-1:0][WIDTH-1:0]  op_b_q;

    // What each stage would load on the next advance.
    logic [STAGES-1:0]             src_cin;
    logic [STAGES-1:0][WIDTH-1:0]  src_a;
    logic [STAGES-1:0][WIDTH-1:0]  src_b;
    logic [STAGES-1:0][WIDTH-1:0]  src_sum;
    logic [STAGES-1:0]             nxt_carry;
    logic [STAGES-1:0][WIDTH-1:0]  nxt_sum;

`ifdef PIPELINED_ADDER_SUB_EN
    // Subtract is folded in at the entry: invert b and inject a carry-in of 1.
    assign b_eff = bus.sub ? ~bus.b : bus.b;
    assign cin0  = bus.sub;
`else
    assign b_eff = bus.b;
    assign cin0  = 1'b0;
`endif

    assign adv          = !valid_q[STAGES-1] || bus.out_ready;
    assign bus.in_ready = adv && !rst;
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.c         = {carry_q[STAGES-1], sum_q[STAGES-1]};

    // Route each stage's inputs: stage 0 from the ports, stage k from stage k-1.
    always_comb begin
        src_a[0]   = bus.a;
        src_b[0]   = b_eff;
        src_sum[0] = '0;
        src_cin[0] = cin0;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k]   = op_a_q[k-1];
            src_b[k]   = op_b_q[k-1];
            src_sum[k] = sum_q[k-1];
            src_cin[k] = carry_q[k-1];
        end
    end

    // Resolve chunk k of the carry chain and splice it into the partial sum.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        nxt_sum   = src_sum;
        nxt_carry = '0;
        for (int k = 0; k < STAGES; k++) begin
            {nxt_carry[k], nxt_sum[k][k*CW +: CW]} =
                {1'b0, src_a[k][k*CW +: CW]} +
                {1'b0, src_b[k][k*CW +: CW]} +
                {{CW{1'b0}}, src_cin[k]};
        end
    end

    // Pipeline registers: clear on reset, shift together on advance, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data and carry registers are cleared along with the valid
            // bits so c reads 0 in the cycle after reset, not stale sums.
            valid_q <= '0;
            carry_q <= '0;
            sum_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else if (adv) begin
            // NOTE: non-blocking assignments make every stage load its
            // predecessor's pre-edge value regardless of statement order.
            valid_q[0] <= accept;
            for (int k = 1; k < STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
            end
            carry_q <= nxt_carry;
            sum_q   <= nxt_sum;
            op_a_q  <= src_a;
            op_b_q  <= src_b;
        end
    end

    // The last stage's operand copies have no consumer.
    logic unused_ops;
    assign unused_ops = ^{op_a_q[STAGES-1], op_b_q[STAGES-1]};
endmodule
